nes_ctrl_reader: RTL

Initiator side of the NES-style serial controller link: periodically latches the gamepad's parallel button state, clocks it out bit by bit with latch/pulse strobes, and deserializes the active-low data line into an 8-bit active-high button vector. It sits between the off-chip controller port and the game logic (player movement and fire). It is the master counterpart to the controller's parallel-in/serial-out shifter.

---
 rtl/nes_ctrl_reader.sv | 110 +++++++++++
 1 files changed

// File: rtl/nes_ctrl_reader.sv
// Master side of an NES-style serial gamepad link: strobes latch/pulse, deserializes
// the active-low data line LSB first and publishes an active-high button vector.
module nes_ctrl_reader #(
    parameter int HALF_CYCLES = 4,
    parameter int POLL_GAP    = 64
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       enable,
    input  logic       data_in,
    output logic       latch,
    output logic       pulse,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);
    localparam int PW = $clog2(2 * HALF_CYCLES);
    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [PW-1:0] PH_LATCH_END = PW'(2 * HALF_CYCLES - 1);
    localparam logic [PW-1:0] PH_HALF_END  = PW'(HALF_CYCLES - 1);
    localparam logic [GW-1:0] GAP_END      = GW'(POLL_GAP - 1);

    typedef enum logic [2:0] {IDLE, LATCH, WAIT, PULSE_HI, PULSE_LO, DONE} state_t;

    state_t        state;
    logic [PW-1:0] phase;
    logic [GW-1:0] gap;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic [1:0]    sync_q;
    logic          d_s;

    // Line idles high (released), so the synchronizer resets to 1.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], data_in};
    end
    assign d_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state   <= IDLE;
            phase   <= '0;
            gap     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            latch   <= 1'b0;
            pulse   <= 1'b0;
            buttons <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            phase <= phase + 1'b1;
            case (state)
                IDLE: begin
                    phase <= '0;
                    if (!enable) begin
                        gap <= '0;
                    end else if (gap == GAP_END) begin
                        gap   <= '0;
                        state <= LATCH;
                        latch <= 1'b1;
                        busy  <= 1'b1;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                LATCH: if (phase == PH_LATCH_END) begin
                    phase <= '0;
                    latch <= 1'b0;
                    state <= WAIT;
                end
                WAIT: if (phase == PH_HALF_END) begin
                    phase    <= '0;
                    shreg[0] <= d_s;
                    bit_cnt  <= 3'd1;
                    pulse    <= 1'b1;
                    state    <= PULSE_HI;
                end
                PULSE_HI: if (phase == PH_HALF_END) begin
                    phase <= '0;
                    pulse <= 1'b0;
                    state <= PULSE_LO;
                end
                PULSE_LO: if (phase == PH_HALF_END) begin
                    phase          <= '0;
                    shreg[bit_cnt] <= d_s;
                    if (bit_cnt == 3'd7) begin
                        // Publish on DONE entry so buttons and valid appear in the DONE cycle.
                        buttons <= ~{d_s, shreg[6:0]};
                        valid   <= 1'b1;
                        state   <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        pulse   <= 1'b1;
                        state   <= PULSE_HI;
                    end
                end
                DONE: begin
                    phase   <= '0;
                    bit_cnt <= '0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
